// File: rtl/aq_gemac_tx_arb.sv
// Two-queue transmit arbiter in front of the GEMAC TX engine.
// Picks a queue per frame (strict or round-robin), muxes its buffer to the MAC and keeps the grant across collision retries.
module aq_gemac_tx_arb #(
   parameter int unsigned COL_W = 5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STRICT_PRIO,
   input  logic [3:0]  MAX_RETRY,
   input  logic [1:0]  Q_TX_REQ,
   input  logic [1:0]  Q_BUFF_EOP,
   input  logic [15:0] Q_BUFF_DATA,
   output logic [1:0]  Q_BUFF_RD,
   output logic [1:0]  Q_BUFF_RETRY,
   output logic [1:0]  Q_BUFF_FINISH,
   output logic [1:0]  Q_DROP,
   output logic        MAC_TX_REQ,
   input  logic        MAC_BUFF_RD,
   output logic        MAC_BUFF_EOP,
   output logic [7:0]  MAC_BUFF_DATA,
   input  logic        MAC_BUFF_FINISH,
   input  logic        MAC_BUFF_RETRY,
   output logic [1:0]  GRANT
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t           state, stateNext;
   logic [1:0]       grantQ, grantNext;
   logic             rrPtr, rrPtrNext;
   logic [COL_W-1:0] colCnt, colCntNext, cntUpd, retryLimit;
   logic             retryFlag, retryFlagNext, flagUpd;
   logic             finLast, retLast, finEdge, retEdge;
   logic             curReq;
   logic [1:0]       idleGrant;
   logic [1:0]       finishQ, dropQ, finishNext, dropNext;

   assign finEdge = MAC_BUFF_FINISH & ~finLast;
   assign retEdge = MAC_BUFF_RETRY & ~retLast;
   assign curReq  = |(Q_TX_REQ & grantQ);

   // Collision bookkeeping as it stands after this cycle's retry edge
   assign cntUpd     = (retEdge && (colCnt != '1)) ? colCnt + COL_W'(1) : colCnt;
   assign flagUpd    = retryFlag | retEdge;
   assign retryLimit = COL_W'(MAX_RETRY) + COL_W'(1);

   assign idleGrant = (Q_TX_REQ == 2'b11) ? ((STRICT_PRIO || !rrPtr) ? 2'b01 : 2'b10)
                                          : Q_TX_REQ;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         grantQ    <= '0;
         rrPtr     <= 1'b0;
         colCnt    <= '0;
         retryFlag <= 1'b0;
         finLast   <= 1'b0;
         retLast   <= 1'b0;
         finishQ   <= '0;
         dropQ     <= '0;
      end else begin
         state     <= stateNext;
         grantQ    <= grantNext;
         rrPtr     <= rrPtrNext;
         colCnt    <= colCntNext;
         retryFlag <= retryFlagNext;
         finLast   <= MAC_BUFF_FINISH;
         retLast   <= MAC_BUFF_RETRY;
         finishQ   <= finishNext;
         dropQ     <= dropNext;
      end
   end

   always_comb begin
      stateNext     = state;
      grantNext     = grantQ;
      rrPtrNext     = rrPtr;
      colCntNext    = colCnt;
      retryFlagNext = retryFlag;
      finishNext    = '0;
      dropNext      = '0;
      case (state)
         S_IDLE: begin
            if (|Q_TX_REQ) begin
               grantNext     = idleGrant;
               colCntNext    = '0;
               retryFlagNext = 1'b0;
               stateNext     = S_GRANT;
            end
         end
         S_GRANT: begin
            // A finish edge here is a pause frame: nothing consumed, grant stays
            if (MAC_BUFF_RD) begin
               stateNext = S_BUSY;
            end else if (!curReq) begin
               grantNext = '0;
               stateNext = S_IDLE;
            end
         end
         S_BUSY: begin
            colCntNext    = cntUpd;
            retryFlagNext = flagUpd;
            if (finEdge) begin
               if (flagUpd && (cntUpd <= retryLimit)) begin
                  retryFlagNext = 1'b0;
                  stateNext     = S_GRANT;
               end else begin
                  finishNext = grantQ;
                  dropNext   = flagUpd ? grantQ : 2'b00;
                  stateNext  = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            rrPtrNext = grantQ[0];
            grantNext = '0;
            stateNext = S_IDLE;
         end
         default: begin
            stateNext = S_IDLE;
         end
      endcase
   end

   // Level-transparent datapath toward the MAC and the buffers
   assign GRANT         = grantQ;
   assign Q_BUFF_FINISH = finishQ;
   assign Q_DROP        = dropQ;
   assign MAC_BUFF_DATA = grantQ[0] ? Q_BUFF_DATA[7:0] : (grantQ[1] ? Q_BUFF_DATA[15:8] : 8'h00);
   assign MAC_BUFF_EOP  = grantQ[0] ? Q_BUFF_EOP[0] : (grantQ[1] ? Q_BUFF_EOP[1] : 1'b0);
   assign Q_BUFF_RD     = (MAC_BUFF_RD && ((state == S_GRANT) || (state == S_BUSY))) ? grantQ : 2'b00;
   assign Q_BUFF_RETRY  = (MAC_BUFF_RETRY && (state == S_BUSY)) ? grantQ : 2'b00;
   assign MAC_TX_REQ    = ((state == S_GRANT) && curReq) || (state == S_BUSY);

endmodule

// File: doc/aq_gemac_tx_arb.md
Name: aq_gemac_tx_arb

Overview:
- Two-queue transmit arbiter in front of the Gigabit MAC transmit engine.
- Selects one of two transmit buffers (queue 0, queue 1) per frame, using strict priority or round-robin.
- Muxes the selected buffer onto the MAC's single buffer interface and holds that grant across collision retries.
- Returns per-queue finish, retry and drop indications. Sits between the TX buffer instances and the MAC TX engine, in the same clock domain.

Parameters:
- COL_W, 5, width of the per-frame collision counter; must hold MAX_RETRY+2.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- STRICT_PRIO  in  1  1: queue 0 always wins a tie; 0: round-robin
- MAX_RETRY  in  4  same value as programmed into the MAC
- Q_TX_REQ  in  2  per-queue frame-ready request, held until that queue's finish
- Q_BUFF_EOP  in  2  per-queue end-of-packet flag
- Q_BUFF_DATA  in  16  queue n data on bits [8n+7:8n]
- Q_BUFF_RD  out  2  per-queue read strobe
- Q_BUFF_RETRY  out  2  per-queue rewind level
- Q_BUFF_FINISH  out  2  per-queue frame-done pulse
- Q_DROP  out  2  per-queue frame-dropped pulse, coincident with finish
- MAC_TX_REQ  out  1  request to MAC
- MAC_BUFF_RD  in  1  read strobe from MAC
- MAC_BUFF_EOP  out  1  muxed EOP
- MAC_BUFF_DATA  out  8  muxed data
- MAC_BUFF_FINISH  in  1  MAC finish level (MAC in defer state)
- MAC_BUFF_RETRY  in  1  MAC retry level (MAC in jam state)
- GRANT  out  2  one-hot current owner, 00 when idle

Behaviour:
- Reset (synchronous, RST=1):
  - state S_IDLE, GRANT=00, round-robin pointer=0.
  - collision count=0, retry flag=0, edge registers=0.
  - All outputs 0.
  - RST mid-frame aborts immediately; no finish or drop pulse is issued.
- Edge detect: FinEdge = MAC_BUFF_FINISH & ~last cycle's value; RetEdge likewise on MAC_BUFF_RETRY. Both are registered every cycle.
- Datapath:
  - MAC_BUFF_DATA and MAC_BUFF_EOP are combinational muxes on GRANT; both are 0 when GRANT=00.
  - Q_BUFF_RD[g] = MAC_BUFF_RD when state is S_GRANT or S_BUSY; otherwise 0.
  - Q_BUFF_RETRY[g] = MAC_BUFF_RETRY when state is S_BUSY.
  - MAC_TX_REQ = (S_GRANT & Q_TX_REQ[g]) | S_BUSY.
- S_IDLE:
  - No request: stay in S_IDLE.
  - Exactly one request: grant that queue.
  - Both requesting: STRICT_PRIO=1 grants queue 0; otherwise grant the queue the pointer indicates.
  - On any grant: load GRANT, clear collision count and retry flag, go to S_GRANT. Grant appears 1 cycle after the request is seen.
- S_GRANT (frame not yet started):
  - MAC_BUFF_RD=1 goes to S_BUSY.
  - If Q_TX_REQ[g] drops, go to S_IDLE with no pulses (request withdrawn).
  - FinEdge is ignored here. It covers a MAC pause frame sent while granted: no buffer data was consumed, so the grant is kept.
- S_BUSY:
  - RetEdge: collision count +1 (saturating), retry flag=1.
  - FinEdge with retry flag=1 and collision count <= MAX_RETRY+1: frame is re-sent. Clear retry flag, return to S_GRANT with the same grant; the collision count is kept.
  - FinEdge otherwise: go to S_RELEASE. Drop is latched as (retry flag=1), i.e. collision count >= MAX_RETRY+2.
  - RetEdge and FinEdge in the same cycle: retry is processed first, then the FinEdge rule is evaluated with the updated values.
- S_RELEASE (1 cycle):
  - Q_BUFF_FINISH[g]=1, and Q_DROP[g]=1 if drop was latched.
  - Round-robin pointer = other queue; GRANT=00; go to S_IDLE.
  - A new grant is possible the following cycle.
- Throughput: back-to-back frames from the same queue are allowed only when the other queue is idle, or when STRICT_PRIO=1 and the queue is queue 0.
- 10/100 mode: MAC strobes and levels last 2 cycles. Edge detection guarantees one count or transition per MAC event, and the muxes are level-transparent.
- The collision counter saturates at all-ones and never wraps.

Test Plan:
- Single frame: Q_TX_REQ=01, 64-byte frame, MAC finish level 3 cycles -> GRANT=01 one cycle after request; MAC_TX_REQ=1; Q_BUFF_RD[0] mirrors 64 MAC reads; exactly one Q_BUFF_FINISH[0] pulse; Q_DROP=00; GRANT=00 after.
- Round-robin: STRICT_PRIO=0, both queues requesting continuously, 4 frames -> grant order q0,q1,q0,q1; MAC_BUFF_DATA tracks the granted queue's data.
- Strict priority: STRICT_PRIO=1, both requesting, 3 frames -> q0,q0,q0; q1 is granted only after Q_TX_REQ[0] falls.
- Retry then success: MAX_RETRY=2, two collisions (retry level 17 cycles each, finish after each) then a clean finish -> grant stays 01 throughout; Q_BUFF_RETRY[0] high during both jams; one finish pulse; no drop.
- Retry exhaustion: MAX_RETRY=1, 3 collisions -> at the 3rd finish edge, Q_BUFF_FINISH[0]=1 and Q_DROP[0]=1 in the same cycle, then S_IDLE.
- Pause frame plus reset: finish edge in S_GRANT with no reads -> grant kept and the frame is sent afterwards. Then RST=1 mid-S_BUSY -> next cycle GRANT=00, MAC_TX_REQ=0, no finish or drop pulse.
